// File: rtl/blast_grid_painter_if.sv
// Handshake, game-input and tile-RAM signals of the blast grid painter.
// master = requester / RAM side, slave = blast_grid_painter.
interface blast_grid_painter_if #(
  parameter int COLS_LOG2 = 4,
  parameter int ROWS_LOG2 = 4,
  parameter int LEN_W     = 2,
  parameter int TIMER_W   = 10
);
  localparam int ADDR_W = COLS_LOG2 + ROWS_LOG2;

  logic               start;
  logic               start_ready;
  logic               player;
  logic [LEN_W-1:0]   length_in;
  logic [ADDR_W-1:0]  origin;
  logic [TIMER_W-1:0] timer;
  logic [3:0]         randhex;
  logic [7:0]         mem_rdata;
  logic [ADDR_W-1:0]  mem_addr;
  logic [7:0]         mem_wdata;
  logic               mem_we;
  logic               chain_valid;
  logic [ADDR_W-1:0]  chain_addr;
  logic               done;

  modport master (
    output start, player, length_in, origin, timer, randhex, mem_rdata,
    input  start_ready, mem_addr, mem_wdata, mem_we, chain_valid, chain_addr, done
  );

  modport slave (
    input  start, player, length_in, origin, timer, randhex, mem_rdata,
    output start_ready, mem_addr, mem_wdata, mem_we, chain_valid, chain_addr, done
  );
endinterface

// File: rtl/blast_grid_painter.sv
// Bomb-blast engine: paints a player's explosion in four arms around the
// bomb origin, waits until the game timer reaches the clear time, then
// restores its own explosion tiles.
// Optional macro BLAST_ITEM_DROP_EN: clear code becomes ITEM when
// randhex[3:1] are all ones, otherwise PATH.
module blast_grid_painter #(
  parameter int COLS_LOG2   = 4,
  parameter int ROWS_LOG2   = 4,
  parameter int LEN_W       = 2,
  parameter int MAX_LEN     = 4,
  parameter int TIMER_W     = 10,
  parameter int CLEAR_DELAY = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  blast_grid_painter_if.slave    bus
);
  localparam int ADDR_W = COLS_LOG2 + ROWS_LOG2;
  localparam int LW1    = LEN_W + 1;
  localparam int MW     = $clog2(MAX_LEN + 1);
  localparam int SW     = (LW1 > MW) ? LW1 : MW;

  localparam logic [7:0] TILE_WALL = 8'h00;
  localparam logic [7:0] TILE_PATH = 8'h80;
  localparam logic [7:0] TILE_WOOD = 8'h10;
  localparam logic [7:0] TILE_BOMB = 8'h60;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [ADDR_W-1:0]    ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]    STRIDE   = ONE_A << COLS_LOG2;
  localparam logic [ROWS_LOG2-1:0] ROW_LAST = {ROWS_LOG2{1'b1}};
  localparam logic [COLS_LOG2-1:0] COL_LAST = {COLS_LOG2{1'b1}};
  localparam logic [SW-1:0]        LEN_MAX  = SW'(MAX_LEN);
  localparam logic [SW-1:0]        ONE_S    = SW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM_STEP, S_ARM_CHECK, S_CENTER,
    S_HOLD, S_CLR_STEP, S_CLR_CHECK, S_CLR_CENTER
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          dir_q, dir_d;
  logic [SW-1:0]       step_q, step_d;
  logic [SW-1:0]       len_q, len_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   origin_q, origin_d;
  logic                player_q, player_d;
  logic [TIMER_W-1:0]  clear_time_q, clear_time_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                chain_valid_q, chain_valid_d;
  logic [ADDR_W-1:0]   chain_addr_q, chain_addr_d;
  logic                done_q, done_d;
  logic                start_ready_q;

  logic                at_edge_s;
  logic                arm_end_s;
  logic                clear_hit_s;
  logic [ADDR_W-1:0]   nbr_s;
  logic [SW-1:0]       len_ext_s;
  logic [7:0]          expl_s;
  logic [7:0]          clr_code_s;
  logic [ROWS_LOG2-1:0] cur_row_s;
  logic [COLS_LOG2-1:0] cur_col_s;

  assign cur_row_s   = cur_q[ADDR_W-1:COLS_LOG2];
  assign cur_col_s   = cur_q[COLS_LOG2-1:0];
  assign expl_s      = {4'h4, player_q, 3'b000};
  assign len_ext_s   = SW'(bus.length_in) + ONE_S;
  assign arm_end_s   = (step_q == len_q) || at_edge_s;
  assign clear_hit_s = (bus.timer == clear_time_q);

`ifdef BLAST_ITEM_DROP_EN
  assign clr_code_s = (bus.randhex[3] & bus.randhex[2] & bus.randhex[1]) ?
                      {4'h9, 3'b000, ~player_q} : TILE_PATH;
`else
  assign clr_code_s = TILE_PATH;
`endif

  // Arm geometry: is the current cell on the grid edge in the walk direction, and its neighbour.
  always_comb begin
    at_edge_s = 1'b1;
    nbr_s     = cur_q;
    case (dir_q)
      DIR_UP:    begin at_edge_s = (cur_row_s == {ROWS_LOG2{1'b0}}); nbr_s = cur_q - STRIDE; end
      DIR_DOWN:  begin at_edge_s = (cur_row_s == ROW_LAST);          nbr_s = cur_q + STRIDE; end
      DIR_LEFT:  begin at_edge_s = (cur_col_s == {COLS_LOG2{1'b0}}); nbr_s = cur_q - ONE_A;  end
      DIR_RIGHT: begin at_edge_s = (cur_col_s == COL_LAST);          nbr_s = cur_q + ONE_A;  end
      default:   begin at_edge_s = 1'b1;                             nbr_s = cur_q;          end
    endcase
  end

  // State and datapath registers; synchronous reset drops any blast in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      dir_q         <= DIR_UP;
      step_q        <= {SW{1'b0}};
      len_q         <= {SW{1'b0}};
      cur_q         <= {ADDR_W{1'b0}};
      origin_q      <= {ADDR_W{1'b0}};
      player_q      <= 1'b0;
      clear_time_q  <= {TIMER_W{1'b0}};
      mem_addr_q    <= {ADDR_W{1'b0}};
      mem_wdata_q   <= 8'h00;
      mem_we_q      <= 1'b0;
      chain_valid_q <= 1'b0;
      chain_addr_q  <= {ADDR_W{1'b0}};
      done_q        <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      step_q        <= step_d;
      len_q         <= len_d;
      cur_q         <= cur_d;
      origin_q      <= origin_d;
      player_q      <= player_d;
      clear_time_q  <= clear_time_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      chain_valid_q <= chain_valid_d;
      chain_addr_q  <= chain_addr_d;
      done_q        <= done_d;
      start_ready_q <= (state_d == S_IDLE);
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       state_d = bus.start ? S_ARM_STEP : S_IDLE;
      S_ARM_STEP:   if (arm_end_s) state_d = (dir_q == DIR_RIGHT) ? S_CENTER : S_ARM_STEP;
                    else           state_d = S_ARM_CHECK;
      S_ARM_CHECK:  state_d = S_ARM_STEP;
      S_CENTER:     state_d = S_HOLD;
      S_HOLD:       state_d = clear_hit_s ? S_CLR_STEP : S_HOLD;
      S_CLR_STEP:   if (arm_end_s) state_d = (dir_q == DIR_RIGHT) ? S_CLR_CENTER : S_CLR_STEP;
                    else           state_d = S_CLR_CHECK;
      S_CLR_CHECK:  state_d = S_CLR_STEP;
      S_CLR_CENTER: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values per state.
  always_comb begin
    dir_d         = dir_q;
    step_d        = step_q;
    len_d         = len_q;
    cur_d         = cur_q;
    origin_d      = origin_q;
    player_d      = player_q;
    clear_time_d  = clear_time_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = 1'b0;
    chain_valid_d = 1'b0;
    chain_addr_d  = chain_addr_q;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          origin_d     = bus.origin;
          player_d     = bus.player;
          len_d        = (len_ext_s > LEN_MAX) ? LEN_MAX : len_ext_s;
          clear_time_d = bus.timer + TIMER_W'(CLEAR_DELAY);
          dir_d        = DIR_UP;
          cur_d        = bus.origin;
          step_d       = {SW{1'b0}};
        end else begin
          dir_d = dir_q;
        end
      end
      S_ARM_STEP, S_CLR_STEP: begin
        if (arm_end_s) begin
          // Wraps RIGHT back to UP, ready for the next phase.
          dir_d  = dir_q + 2'd1;
          cur_d  = origin_q;
          step_d = {SW{1'b0}};
        end else begin
          cur_d      = nbr_s;
          mem_addr_d = nbr_s;
          step_d     = step_q + ONE_S;
        end
      end
      S_ARM_CHECK: begin
        case (bus.mem_rdata)
          TILE_WALL: step_d = len_q;
          TILE_BOMB: begin
            step_d        = len_q;
            chain_valid_d = 1'b1;
            chain_addr_d  = cur_q;
          end
          TILE_WOOD: begin
            step_d      = len_q;
            mem_we_d    = 1'b1;
            mem_wdata_d = expl_s;
            mem_addr_d  = cur_q;
          end
          default: begin
            mem_we_d    = 1'b1;
            mem_wdata_d = expl_s;
            mem_addr_d  = cur_q;
          end
        endcase
      end
      S_CENTER: begin
        mem_we_d    = 1'b1;
        mem_wdata_d = expl_s;
        mem_addr_d  = origin_q;
      end
      S_HOLD: begin
        if (clear_hit_s) begin
          dir_d  = DIR_UP;
          cur_d  = origin_q;
          step_d = {SW{1'b0}};
        end else begin
          dir_d = dir_q;
        end
      end
      S_CLR_CHECK: begin
        if (bus.mem_rdata == expl_s) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = clr_code_s;
          mem_addr_d  = cur_q;
        end else if (bus.mem_rdata == TILE_WALL) begin
          step_d = len_q;
        end else begin
          step_d = step_q;
        end
      end
      S_CLR_CENTER: begin
        mem_we_d    = 1'b1;
        mem_wdata_d = clr_code_s;
        mem_addr_d  = origin_q;
        done_d      = 1'b1;
      end
      default: begin
        mem_we_d = 1'b0;
      end
    endcase
  end

  assign bus.start_ready = start_ready_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.chain_valid = chain_valid_q;
  assign bus.chain_addr  = chain_addr_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_blast_grid_painter.sv
// Self-checking bench for blast_grid_painter: a 256-tile map, a game timer
// ticking every 64 clocks, and a reference model that walks the arms with
// row/column arithmetic on a copy of the map.
module tb_blast_grid_painter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  blast_grid_painter_if bif ();
  blast_grid_painter dut (.clk(clk), .reset(reset), .bus(bif));

  logic [7:0] ram [0:255];
  logic [7:0] mm  [0:255];
  assign bif.mem_rdata = ram[bif.mem_addr];

  logic       tload;
  logic [9:0] tload_val;
  logic [9:0] timer_v;
  int         tick_cnt;
  assign bif.timer = timer_v;

  // Game timer: one tick every 64 clocks, loadable from the stimulus.
  always @(posedge clk) begin
    if (tload) begin
      timer_v  <= tload_val;
      tick_cnt <= 0;
    end else if (tick_cnt == 63) begin
      timer_v  <= timer_v + 10'd1;
      tick_cnt <= 0;
    end else begin
      tick_cnt <= tick_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int DR [4] = '{-1, 1, 0, 0};
  int DC [4] = '{0, 0, -1, 1};
  logic [15:0] exp_w[$], act_w[$];
  logic [7:0]  exp_c[$], act_c[$];
  logic [3:0]  cur_rh;
  logic [9:0]  done_timer;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int arm_len(input logic [1:0] lc);
    return (int'(lc) + 1 > 4) ? 4 : int'(lc) + 1;
  endfunction

  task automatic model_paint(input logic [7:0] org, input logic [1:0] lc, input logic pl);
    int r, c, a;
    logic [7:0] t, ex;
    ex = {4'h4, pl, 3'b000};
    for (int d = 0; d < 4; d++) begin
      for (int k = 1; k <= arm_len(lc); k++) begin
        r = int'(org[7:4]) + DR[d] * k;
        c = int'(org[3:0]) + DC[d] * k;
        if (r < 0 || r > 15 || c < 0 || c > 15) break;
        a = r * 16 + c;
        t = mm[a];
        if (t == 8'h00) break;
        if (t == 8'h60) begin exp_c.push_back(8'(a)); break; end
        exp_w.push_back({8'(a), ex});
        mm[a] = ex;
        if (t == 8'h10) break;
      end
    end
    exp_w.push_back({org, ex});
    mm[org] = ex;
  endtask

  task automatic model_clear(input logic [7:0] org, input logic [1:0] lc, input logic pl,
                             input logic [7:0] clr);
    int r, c, a;
    logic [7:0] ex;
    ex = {4'h4, pl, 3'b000};
    for (int d = 0; d < 4; d++) begin
      for (int k = 1; k <= arm_len(lc); k++) begin
        r = int'(org[7:4]) + DR[d] * k;
        c = int'(org[3:0]) + DC[d] * k;
        if (r < 0 || r > 15 || c < 0 || c > 15) break;
        a = r * 16 + c;
        if (mm[a] == ex) begin
          exp_w.push_back({8'(a), clr});
          mm[a] = clr;
        end else if (mm[a] == 8'h00) begin
          break;
        end
      end
    end
    exp_w.push_back({org, clr});
    mm[org] = clr;
  endtask

  task automatic fill_map(input bit rnd);
    logic [7:0] t;
    for (int i = 0; i < 256; i++) begin
      t = 8'h80;
      if (rnd) begin
        case ($urandom_range(0, 9))
          5: t = 8'h00;
          6: t = 8'h10;
          7: t = 8'h60;
          8: t = ($urandom_range(0, 1) == 0) ? 8'h40 : 8'h48;
          9: t = ($urandom_range(0, 1) == 0) ? 8'h90 : 8'h91;
          default: t = 8'h80;
        endcase
      end
      ram[i] = t;
      mm[i]  = t;
    end
  endtask

  task automatic set_tile(input logic [7:0] a, input logic [7:0] t);
    ram[a] = t;
    mm[a]  = t;
  endtask

  // Advances up to budget cycles, applying DUT writes to the map and logging them.
  task automatic observe(input int budget, output bit got_done, output int ready_bad);
    got_done  = 1'b0;
    ready_bad = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
`ifdef BLAST_ITEM_DROP_EN
      bif.randhex = cur_rh;
`else
      bif.randhex = 4'($urandom);
`endif
      if (bif.mem_we === 1'b1) begin
        act_w.push_back({bif.mem_addr, bif.mem_wdata});
        ram[bif.mem_addr] = bif.mem_wdata;
      end
      if (bif.chain_valid === 1'b1) act_c.push_back(bif.chain_addr);
      if (bif.done === 1'b1) begin
        got_done   = 1'b1;
        done_timer = timer_v;
        break;
      end
      if (bif.start_ready !== 1'b0) ready_bad++;
    end
  endtask

  task automatic start_blast(input logic [7:0] org, input logic [1:0] lc, input logic pl,
                             output logic [9:0] ct);
    int w;
    w = 0;
    while (bif.start_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    chk("ready_before_start", bif.start_ready, 1);
    bif.start     = 1'b1;
    bif.origin    = org;
    bif.length_in = lc;
    bif.player    = pl;
    ct = timer_v + 10'd8;
    @(negedge clk);
    bif.start     = 1'b0;
    bif.origin    = 8'($urandom);
    bif.length_in = 2'($urandom);
    bif.player    = 1'($urandom);
  endtask

  task automatic compare(input string tag);
    int mis;
    chk({tag, "_nwrites"}, act_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < act_w.size(); i++)
      chk($sformatf("%s_write%0d", tag, i), act_w[i], exp_w[i]);
    chk({tag, "_nchain"}, act_c.size(), exp_c.size());
    for (int i = 0; i < exp_c.size() && i < act_c.size(); i++)
      chk($sformatf("%s_chain%0d", tag, i), act_c[i], exp_c[i]);
    mis = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== mm[i]) mis++;
    chk({tag, "_map"}, mis, 0);
  endtask

  task automatic run_blast(input string tag, input logic [7:0] org, input logic [1:0] lc,
                           input logic pl, input logic [3:0] rh, input bit stray);
    logic [7:0] clr;
    logic [9:0] ct;
    bit gd;
    int rb, rb2;
    exp_w.delete(); act_w.delete(); exp_c.delete(); act_c.delete();
    cur_rh = rh;
`ifdef BLAST_ITEM_DROP_EN
    clr = (rh[3] & rh[2] & rh[1]) ? {4'h9, 3'b000, ~pl} : 8'h80;
`else
    clr = 8'h80;
`endif
    model_paint(org, lc, pl);
    model_clear(org, lc, pl, clr);
    start_blast(org, lc, pl, ct);
    observe(200, gd, rb);
    if (stray) begin
      bif.start     = 1'b1;
      bif.origin    = org ^ 8'h11;
      bif.length_in = 2'd3;
      bif.player    = ~pl;
      observe(1, gd, rb2);
      rb += rb2;
      bif.start = 1'b0;
    end
    observe(2000, gd, rb2);
    rb += rb2;
    chk({tag, "_done_seen"}, gd, 1);
    chk({tag, "_ready_low_busy"}, rb, 0);
    chk({tag, "_timer_at_done"}, done_timer, ct);
    @(negedge clk);
    chk({tag, "_done_single"}, bif.done, 0);
    chk({tag, "_ready_after"}, bif.start_ready, 1);
    compare(tag);
  endtask

  initial begin
    bit gd;
    int rb, nw;
    logic [9:0] ct;
    reset = 1'b1;
    bif.start = 1'b0; bif.player = 1'b0; bif.length_in = 2'd0;
    bif.origin = 8'h00; bif.randhex = 4'h0;
    cur_rh = 4'h0; done_timer = 10'h000;
    tload = 1'b1; tload_val = 10'h000;
    fill_map(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_mem_we", bif.mem_we, 0);
    chk("rst_mem_addr", bif.mem_addr, 0);
    chk("rst_mem_wdata", bif.mem_wdata, 0);
    chk("rst_chain_valid", bif.chain_valid, 0);
    chk("rst_chain_addr", bif.chain_addr, 0);
    chk("rst_done", bif.done, 0);
    reset = 1'b0;
    tload = 1'b0;
    @(negedge clk);
    chk("rst_ready", bif.start_ready, 1);

    // All-path map, short arms.
    run_blast("t1", 8'h55, 2'd1, 1'b0, 4'h0, 1'b0);
    chk("t1_first_write", (act_w.size() > 0) ? act_w[0] : 16'h0000, 16'h4540);
    chk("t1_center_write", (act_w.size() > 8) ? act_w[8] : 16'h0000, 16'h5540);

    // Wall, wood and bomb stop their arms.
    fill_map(1'b0);
    set_tile(8'h45, 8'h00); set_tile(8'h65, 8'h10); set_tile(8'h54, 8'h60);
    run_blast("t2", 8'h55, 2'd3, 1'b0, 4'h0, 1'b0);
    chk("t2_chain_addr", (act_c.size() > 0) ? act_c[0] : 8'hFF, 8'h54);
    chk("t2_bomb_kept", ram[8'h54], 8'h60);

    // Corner origin: UP and LEFT blocked by the grid edge.
    fill_map(1'b0);
    run_blast("t3", 8'h00, 2'd3, 1'b0, 4'h0, 1'b0);
    chk("t3_first_write", (act_w.size() > 0) ? act_w[0] : 16'h0000, 16'h1040);

    // Timer wrap, other player's explosion left alone, start while busy ignored.
    fill_map(1'b0);
    set_tile(8'h56, 8'h10); set_tile(8'h57, 8'h48);
    @(negedge clk); tload_val = 10'h3FC; tload = 1'b1;
    @(negedge clk); tload = 1'b0;
    run_blast("t4", 8'h55, 2'd3, 1'b0, 4'h0, 1'b1);
    chk("t4_wrap_clear_time", done_timer, 10'h004);
    chk("t4_other_player", ram[8'h57], 8'h48);

`ifdef BLAST_ITEM_DROP_EN
    fill_map(1'b0);
    run_blast("t5e", 8'h55, 2'd1, 1'b0, 4'hE, 1'b0);
    chk("t5e_last", (act_w.size() > 0) ? act_w[act_w.size()-1] : 16'h0000, 16'h5591);
    fill_map(1'b0);
    run_blast("t56", 8'h55, 2'd1, 1'b0, 4'h6, 1'b0);
    chk("t56_last", (act_w.size() > 0) ? act_w[act_w.size()-1] : 16'h0000, 16'h5580);
`endif

    // Reset during HOLD abandons the clear phase.
    fill_map(1'b1);
    exp_w.delete(); act_w.delete(); exp_c.delete(); act_c.delete();
    model_paint(8'h77, 2'd2, 1'b1);
    start_blast(8'h77, 2'd2, 1'b1, ct);
    observe(150, gd, rb);
    chk("t6_no_done_in_hold", gd, 0);
    compare("t6_paint");
    nw = act_w.size();
    reset = 1'b1;
    observe(2, gd, rb);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_ready_after_reset", bif.start_ready, 1);
    observe(700, gd, rb);
    chk("t6_no_writes_after_reset", act_w.size(), nw);
    chk("t6_no_done_after_reset", gd, 0);
    run_blast("t6_new", 8'h77, 2'd0, 1'b0, 4'($urandom), 1'b0);

    // Randomised blasts on random maps.
    for (int n = 0; n < 8; n++) begin
      fill_map(1'b1);
      @(negedge clk); tload_val = 10'($urandom); tload = 1'b1;
      @(negedge clk); tload = 1'b0;
      run_blast($sformatf("rnd%0d", n), 8'($urandom), 2'($urandom), 1'($urandom),
                4'($urandom), n[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
